// File: rtl/awg_pkg.sv
// Shared types, width defaults and the frame-length decode for the AWG memory loader.
// No clocked logic lives here.
package awg_pkg;

  localparam int DAC_DATA_WIDTH_DEF = 14;
  localparam int ADDR_WIDTH_DEF     = 16;
  localparam int WORD_WIDTH_DEF     = 16;
  localparam int ADDR_W_MAX         = 16;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    HDR_LEN = 2'd1,
    DATA    = 2'd2,
    TRAILER = 2'd3
  } ld_state_e;

  // A zero length field stands for a full memory of 2^aw samples.
  function automatic logic [ADDR_W_MAX:0] length_decode(
    input logic [ADDR_W_MAX-1:0] n_field,
    input int unsigned           aw
  );
    logic [ADDR_W_MAX:0]   full;
    logic [ADDR_W_MAX-1:0] mask;
    full = (ADDR_W_MAX+1)'(1) << aw;
    mask = ADDR_W_MAX'(full - (ADDR_W_MAX+1)'(1));
    if ((n_field & mask) == '0) begin
      length_decode = full;
    end else begin
      length_decode = {1'b0, n_field & mask};
    end
  endfunction

endpackage

// File: rtl/awg_sum16.sv
// Clearable, enabled modular accumulator (sum of words mod 2^W); result visible the cycle after en.
// No flow control: clr wins over en.
module awg_sum16 #(
  parameter int W = 16
) (
  input  logic         wclk,
  input  logic         rst_n,
  input  logic         clr_i,
  input  logic         en_i,
  input  logic [W-1:0] din_i,
  output logic [W-1:0] sum_o
);

  logic [W-1:0] sum_q;
  logic [W-1:0] sum_d;

  always_comb begin
    sum_d = sum_q;
    if (clr_i) begin
      sum_d = '0;
    end else if (en_i) begin
      sum_d = sum_q + din_i;
    end
  end

  always_ff @(posedge wclk) begin
    if (!rst_n) begin
      sum_q <= '0;
    end else begin
      sum_q <= sum_d;
    end
  end

  assign sum_o = sum_q;

endmodule

// File: rtl/awg_mem_loader.sv
// Unpacks framed header/length/data/trailer words into waveform-memory writes one cycle after accept.
// Never back-pressures (s_ready tied high); abort drops the frame in flight.
module awg_mem_loader
  import awg_pkg::*;
#(
  parameter int DAC_DATA_WIDTH = DAC_DATA_WIDTH_DEF,
  parameter int ADDR_WIDTH     = ADDR_WIDTH_DEF,
  parameter int WORD_WIDTH     = WORD_WIDTH_DEF
) (
  input  logic                      wclk,
  input  logic                      rst_n,
  input  logic [WORD_WIDTH-1:0]     s_data,
  input  logic                      s_valid,
  output logic                      s_ready,
  input  logic                      abort,
  output logic                      mem_we,
  output logic [ADDR_WIDTH-1:0]     mem_waddr,
  output logic [DAC_DATA_WIDTH-1:0] mem_wdata,
  output logic                      busy,
  output logic                      done,
  output logic                      sum_err,
  output logic [ADDR_WIDTH:0]       words_loaded
);

  ld_state_e                 state_q, state_d;
  logic [ADDR_WIDTH-1:0]     addr_q, addr_d;
  logic [ADDR_WIDTH:0]       rem_q, rem_d;
  logic [ADDR_WIDTH:0]       wl_q, wl_d;
  logic                      we_q, we_d;
  logic [ADDR_WIDTH-1:0]     waddr_q, waddr_d;
  logic [DAC_DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic                      busy_q, busy_d;
  logic                      done_q, done_d;
  logic                      err_q, err_d;

  logic                      accept;
  logic                      acc_clr;
  logic                      acc_en;
  logic [WORD_WIDTH-1:0]     acc_sum;
  logic [ADDR_W_MAX-1:0]     len_field;
  logic [ADDR_W_MAX:0]       len_full;

  assign s_ready   = 1'b1;
  assign accept    = s_valid && s_ready;
  assign len_field = ADDR_W_MAX'(s_data[ADDR_WIDTH-1:0]);
  assign len_full  = length_decode(len_field, ADDR_WIDTH);

  awg_sum16 #(
    .W (WORD_WIDTH)
  ) u_sum (
    .wclk  (wclk),
    .rst_n (rst_n),
    .clr_i (acc_clr),
    .en_i  (acc_en),
    .din_i (s_data),
    .sum_o (acc_sum)
  );

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    rem_d   = rem_q;
    wl_d    = wl_q;
    we_d    = 1'b0;
    waddr_d = waddr_q;
    wdata_d = wdata_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    err_d   = err_q;
    acc_clr = 1'b0;
    acc_en  = 1'b0;

    // abort discards any word presented alongside it; sum_err and words_loaded survive
    if (abort) begin
      state_d = IDLE;
      busy_d  = 1'b0;
    end else if (accept) begin
      unique case (state_q)
        IDLE: begin
          addr_d  = s_data[ADDR_WIDTH-1:0];
          wl_d    = '0;
          err_d   = 1'b0;
          busy_d  = 1'b1;
          state_d = HDR_LEN;
        end
        HDR_LEN: begin
          rem_d   = len_full[ADDR_WIDTH:0];
          acc_clr = 1'b1;
          state_d = DATA;
        end
        DATA: begin
          we_d    = 1'b1;
          waddr_d = addr_q;
          wdata_d = s_data[DAC_DATA_WIDTH-1:0];
          addr_d  = addr_q + 1'b1;
          acc_en  = 1'b1;
          wl_d    = wl_q + 1'b1;
          rem_d   = rem_q - 1'b1;
          if (rem_q == {{ADDR_WIDTH{1'b0}}, 1'b1}) begin
            state_d = TRAILER;
          end
        end
        TRAILER: begin
          if (s_data == acc_sum) begin
            done_d = 1'b1;
          end else begin
            err_d = 1'b1;
          end
          busy_d  = 1'b0;
          state_d = IDLE;
        end
        default: begin
          state_d = IDLE;
          busy_d  = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge wclk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      addr_q  <= '0;
      rem_q   <= '0;
      wl_q    <= '0;
      we_q    <= 1'b0;
      waddr_q <= '0;
      wdata_q <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      rem_q   <= rem_d;
      wl_q    <= wl_d;
      we_q    <= we_d;
      waddr_q <= waddr_d;
      wdata_q <= wdata_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  assign mem_we       = we_q;
  assign mem_waddr    = waddr_q;
  assign mem_wdata    = wdata_q;
  assign busy         = busy_q;
  assign done         = done_q;
  assign sum_err      = err_q;
  assign words_loaded = wl_q;

endmodule

// File: tb/tb_awg_mem_loader.sv
// Bench for awg_mem_loader: directed frames plus random frames with gaps, checked against a frame-level model.
module tb_awg_mem_loader;

  logic        wclk = 1'b0;
  logic        rst_n;
  logic [15:0] s_data;
  logic        s_valid;
  logic        s_ready;
  logic        abort;
  logic        mem_we;
  logic [15:0] mem_waddr;
  logic [13:0] mem_wdata;
  logic        busy;
  logic        done;
  logic        sum_err;
  logic [16:0] words_loaded;

  int vecs = 0;
  int errs = 0;

  always #5 wclk = ~wclk;

  awg_mem_loader dut (
    .wclk         (wclk),
    .rst_n        (rst_n),
    .s_data       (s_data),
    .s_valid      (s_valid),
    .s_ready      (s_ready),
    .abort        (abort),
    .mem_we       (mem_we),
    .mem_waddr    (mem_waddr),
    .mem_wdata    (mem_wdata),
    .busy         (busy),
    .done         (done),
    .sum_err      (sum_err),
    .words_loaded (words_loaded)
  );

  // Present one cycle of inputs (called at a falling edge), then land on the next falling edge.
  task automatic cyc(input logic v, input logic [15:0] d, input logic ab);
    s_valid = v;
    s_data  = d;
    abort   = ab;
    @(posedge wclk);
    @(negedge wclk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    cyc(1'b0, 16'h0000, 1'b0);
    cyc(1'b1, 16'hABCD, 1'b0);
    vecs++;
    if ({mem_we, busy, done, sum_err, s_ready} !== 5'b00001 || mem_waddr !== 16'h0 ||
        mem_wdata !== 14'h0 || words_loaded !== 17'h0) begin
      errs++;
      $display("FAIL reset: we=%b busy=%b done=%b err=%b rdy=%b waddr=%h wdata=%h wl=%0d, want 0/0/0/0/1 and zeros",
               mem_we, busy, done, sum_err, s_ready, mem_waddr, mem_wdata, words_loaded);
    end
    rst_n = 1'b1;
    cyc(1'b0, 16'h0000, 1'b0);
  endtask

  // Drives a whole frame and checks every cycle against what the frame rules imply.
  task automatic run_frame(input string tag, input logic [15:0] start, input logic [15:0] nfield,
                           input logic [15:0] dq[$], input logic [15:0] tr, input int gapmax);
    int          n;
    logic [15:0] sum;
    logic [15:0] ea;
    bit          good;
    n   = (nfield == 16'h0) ? 65536 : int'(nfield);
    sum = 16'h0;
    for (int k = 0; k < n; k++) sum = sum + dq[k];
    good = (tr == sum);

    cyc(1'b1, start, 1'b0);
    vecs++;
    if (busy !== 1'b1 || sum_err !== 1'b0 || words_loaded !== 17'd0 || mem_we !== 1'b0) begin
      errs++;
      $display("FAIL %s hdr_addr: busy=%b err=%b wl=%0d we=%b, want 1/0/0/0", tag, busy, sum_err, words_loaded, mem_we);
    end
    cyc(1'b1, nfield, 1'b0);
    vecs++;
    if (mem_we !== 1'b0 || busy !== 1'b1) begin
      errs++;
      $display("FAIL %s hdr_len: we=%b busy=%b, want 0/1", tag, mem_we, busy);
    end
    for (int i = 0; i < n; i++) begin
      repeat ($urandom_range(gapmax, 0)) begin
        cyc(1'b0, 16'($urandom), 1'b0);
        vecs++;
        if (mem_we !== 1'b0) begin
          errs++;
          $display("FAIL %s gap_we: got %b want 0", tag, mem_we);
        end
      end
      cyc(1'b1, dq[i], 1'b0);
      ea = start + 16'(i);
      vecs++;
      if (mem_we !== 1'b1 || mem_waddr !== ea || mem_wdata !== dq[i][13:0] || words_loaded !== 17'(i + 1)) begin
        errs++;
        $display("FAIL %s write %0d: we=%b addr=%h data=%h wl=%0d, want 1 %h %h %0d",
                 tag, i, mem_we, mem_waddr, mem_wdata, words_loaded, ea, dq[i][13:0], i + 1);
      end
    end
    repeat ($urandom_range(gapmax, 0)) cyc(1'b0, 16'h0, 1'b0);
    cyc(1'b1, tr, 1'b0);
    vecs++;
    if (done !== good || sum_err !== !good || busy !== 1'b0 || mem_we !== 1'b0 || words_loaded !== 17'(n)) begin
      errs++;
      $display("FAIL %s trailer: done=%b err=%b busy=%b we=%b wl=%0d, want %b %b 0 0 %0d",
               tag, done, sum_err, busy, mem_we, words_loaded, good, !good, n);
    end
    cyc(1'b0, 16'h0, 1'b0);
    vecs++;
    if (done !== 1'b0 || sum_err !== !good) begin
      errs++;
      $display("FAIL %s after: done=%b err=%b, want 0 %b", tag, done, sum_err, !good);
    end
  endtask

  task automatic test_directed();
    logic [15:0] dq[$];
    dq = '{16'h0001, 16'h0002, 16'h0003, 16'h3FFF};
    run_frame("basic_good", 16'h0010, 16'h0004, dq, 16'h4005, 0);
    run_frame("basic_bad", 16'h0010, 16'h0004, dq, 16'h4006, 0);
    dq = '{16'h000A, 16'h000B, 16'h000C};
    run_frame("wrap", 16'hFFFE, 16'h0003, dq, 16'h0021, 0);
    dq = '{16'hC123, 16'hFFFF, 16'h8000, 16'h7ABC, 16'h0FFF};
    run_frame("upper_bits_gaps", 16'h1234, 16'h0005, dq, 16'hC123 + 16'hFFFF + 16'h8000 + 16'h7ABC + 16'h0FFF, 3);
  endtask

  task automatic test_toggle();
    logic [15:0] dq[$];
    cyc(1'b1, 16'h0200, 1'b0);
    cyc(1'b1, 16'h0003, 1'b0);
    dq = '{16'h0111, 16'h0222, 16'h0333};
    cyc(1'b1, dq[0], 1'b0);
    vecs++;
    if (mem_we !== 1'b1 || mem_waddr !== 16'h0200) begin
      errs++;
      $display("FAIL toggle w0: we=%b addr=%h want 1 0200", mem_we, mem_waddr);
    end
    cyc(1'b0, 16'h0, 1'b0);
    vecs++;
    if (mem_we !== 1'b0) begin
      errs++;
      $display("FAIL toggle gap1: we=%b want 0", mem_we);
    end
    cyc(1'b0, 16'h0, 1'b0);
    vecs++;
    if (mem_we !== 1'b0 || busy !== 1'b1) begin
      errs++;
      $display("FAIL toggle gap2: we=%b busy=%b want 0 1", mem_we, busy);
    end
    cyc(1'b1, dq[1], 1'b0);
    vecs++;
    if (mem_we !== 1'b1 || mem_waddr !== 16'h0201 || mem_wdata !== 14'h0222) begin
      errs++;
      $display("FAIL toggle w1: we=%b addr=%h data=%h want 1 0201 0222", mem_we, mem_waddr, mem_wdata);
    end
    cyc(1'b1, dq[2], 1'b0);
    cyc(1'b1, 16'h0666, 1'b0);
    vecs++;
    if (done !== 1'b1 || sum_err !== 1'b0) begin
      errs++;
      $display("FAIL toggle trailer: done=%b err=%b want 1 0", done, sum_err);
    end
  endtask

  task automatic test_abort();
    logic [15:0] dq[$];
    cyc(1'b1, 16'h0400, 1'b0);
    cyc(1'b1, 16'h0005, 1'b0);
    cyc(1'b1, 16'h0055, 1'b0);
    cyc(1'b1, 16'h0066, 1'b0);
    cyc(1'b1, 16'h0077, 1'b1);
    vecs++;
    if (mem_we !== 1'b0 || busy !== 1'b0 || words_loaded !== 17'd2 || sum_err !== 1'b0 || done !== 1'b0) begin
      errs++;
      $display("FAIL abort: we=%b busy=%b wl=%0d err=%b done=%b want 0 0 2 0 0", mem_we, busy, words_loaded, sum_err, done);
    end
    cyc(1'b0, 16'h0, 1'b0);
    vecs++;
    if (mem_we !== 1'b0 || busy !== 1'b0 || words_loaded !== 17'd2) begin
      errs++;
      $display("FAIL abort_hold: we=%b busy=%b wl=%0d want 0 0 2", mem_we, busy, words_loaded);
    end
    dq = '{16'h1111, 16'h2222};
    run_frame("post_abort", 16'h0500, 16'h0002, dq, 16'h3333, 1);
  endtask

  task automatic test_reset_mid();
    logic [15:0] dq[$];
    cyc(1'b1, 16'h0700, 1'b0);
    cyc(1'b1, 16'h0004, 1'b0);
    cyc(1'b1, 16'h0AAA, 1'b0);
    cyc(1'b1, 16'h0BBB, 1'b0);
    rst_n = 1'b0;
    cyc(1'b1, 16'h0CCC, 1'b0);
    rst_n = 1'b1;
    vecs++;
    if ({mem_we, busy, done, sum_err, s_ready} !== 5'b00001 || mem_waddr !== 16'h0 ||
        mem_wdata !== 14'h0 || words_loaded !== 17'h0) begin
      errs++;
      $display("FAIL reset_mid: we=%b busy=%b done=%b err=%b rdy=%b waddr=%h wdata=%h wl=%0d",
               mem_we, busy, done, sum_err, s_ready, mem_waddr, mem_wdata, words_loaded);
    end
    dq = '{16'h0042};
    run_frame("post_reset", 16'h0800, 16'h0001, dq, 16'h0042, 0);
  endtask

  task automatic test_random();
    logic [15:0] dq[$];
    logic [15:0] sum;
    logic [15:0] tr;
    int          n;
    for (int f = 0; f < 24; f++) begin
      n = $urandom_range(12, 1);
      dq.delete();
      sum = 16'h0;
      for (int k = 0; k < n; k++) begin
        dq.push_back(16'($urandom));
        sum = sum + dq[k];
      end
      tr = ($urandom_range(3, 0) == 0) ? (sum ^ (16'h1 << $urandom_range(15, 0))) : sum;
      run_frame("random", 16'($urandom), 16'(n), dq, tr, 2);
    end
  endtask

  task automatic test_full_length();
    logic [15:0] dq[$];
    logic [15:0] sum;
    sum = 16'h0;
    for (int k = 0; k < 65536; k++) begin
      dq.push_back(16'($urandom));
      sum = sum + dq[k];
    end
    run_frame("full_len", 16'($urandom), 16'h0000, dq, sum, 0);
  endtask

  initial begin
    rst_n   = 1'b0;
    s_valid = 1'b0;
    s_data  = 16'h0;
    abort   = 1'b0;
    test_reset();
    test_directed();
    test_toggle();
    test_abort();
    test_reset_mid();
    test_random();
    test_full_length();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
